// File: rtl/latch_wr_pkg.sv
// Shared definitions for the latch write sequencer.
//   state_t        : sequencer FSM states (IDLE, SETUP, PULSE, HOLD)
//   CNT_W          : width of the shared phase counter
//   MAX_DEPTH      : largest supported number of latches
//   MAX_PHASE_CYC  : largest supported SETUP_CYC / HOLD_CYC value
package latch_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int CNT_W         = 4;
  localparam int MAX_DEPTH     = 64;
  localparam int MAX_PHASE_CYC = 15;

endpackage

// File: rtl/latch_wr_phase_cnt.sv
// Loadable down-counter timing the SETUP and HOLD phases.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset (count -> 0)
//   load     : load load_val this cycle (priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   zero     : count is zero
module latch_wr_phase_cnt
  import latch_wr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Saturating at zero; the FSM reloads on every state entry so this
  // guard only matters if dec were ever held past the end of a phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_wr_sequencer.sv
// Write sequencer for a bank of level-sensitive D-latches. Each accepted
// write presents data on lat_d for SETUP_CYC cycles, pulses exactly one
// lat_en bit for one cycle, then holds lat_d for HOLD_CYC cycles, so the
// latch input never moves while its enable is high.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   clr_req  : (only with LATCH_WR_SEQ_CLEAR_EN) clear all latches to 0
//   wr_valid : write request
//   wr_ready : sequencer idle and able to accept a write (registered)
//   wr_addr  : target latch index
//   wr_data  : write data
//   lat_en   : one-hot latch enables (registered)
//   lat_d    : shared latch data bus (registered)
//   busy     : sequence in progress
//   err      : one-cycle pulse for an accepted out-of-range address
// Optional feature macro: LATCH_WR_SEQ_CLEAR_EN
module latch_wr_sequencer
  import latch_wr_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef LATCH_WR_SEQ_CLEAR_EN
  input  logic                     clr_req,
`endif
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [DEPTH-1:0]         lat_en,
  output logic [WIDTH-1:0]         lat_d,
  output logic                     busy,
  output logic                     err
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             clr_accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [AW-1:0]    addr_q;
  logic             clr_q;
  logic [DEPTH-1:0] pulse_en;

`ifdef LATCH_WR_SEQ_CLEAR_EN
  assign clr_accept = (state == IDLE) && clr_req;
`else
  assign clr_accept = 1'b0;
`endif

  // A clear in the same cycle wins over a write.
  assign accept = (state == IDLE) && wr_valid && !clr_accept;

  latch_wr_phase_cnt u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    cnt_load     = 1'b0;
    cnt_load_val = SETUP_LD;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (accept || clr_accept) begin
          next_state   = SETUP;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          next_state = PULSE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        next_state   = HOLD;
        cnt_load     = 1'b1;
        cnt_load_val = HOLD_LD;
      end
      HOLD: begin
        if (cnt_zero) begin
          next_state = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Out-of-range addresses decode to no enable at all.
  always_comb begin
    pulse_en = '0;
    if (clr_q) begin
      pulse_en = '1;
    end else if ({1'b0, addr_q} < DEPTH_W) begin
      pulse_en[addr_q] = 1'b1;
    end
  end

  // Outputs are registered off next_state so they line up with the state
  // they describe without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
      lat_en   <= '0;
      lat_d    <= '0;
      addr_q   <= '0;
      clr_q    <= 1'b0;
    end else begin
      wr_ready <= (next_state == IDLE);
      busy     <= (next_state != IDLE);
      err      <= accept && ({1'b0, wr_addr} >= DEPTH_W);
      lat_en   <= (next_state == PULSE) ? pulse_en : '0;
      if (clr_accept) begin
        addr_q <= '0;
        lat_d  <= '0;
        clr_q  <= 1'b1;
      end else if (accept) begin
        addr_q <= wr_addr;
        lat_d  <= wr_data;
        clr_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Self-checking bench for latch_wr_sequencer. A cycle-level reference model
// derived from the sequence timing pushes expected outputs into a queue
// after each clock edge; a separate monitor pops and compares on the
// falling edge. Honours LATCH_WR_SEQ_CLEAR_EN when defined.
module tb_latch_wr_sequencer;

  localparam int DEPTH     = 5;
  localparam int WIDTH     = 8;
  localparam int SETUP_CYC = 3;
  localparam int HOLD_CYC  = 2;
  localparam int AW        = $clog2(DEPTH);
  localparam int SEQ_LEN   = SETUP_CYC + HOLD_CYC + 2;
`ifdef LATCH_WR_SEQ_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct packed {
    logic             ready;
    logic             busy;
    logic             err;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_valid = 1'b0;
  logic             clr_req = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_ready;
  logic             busy;
  logic             err;
  logic [DEPTH-1:0] lat_en;
  logic [WIDTH-1:0] lat_d;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: pos counts edges since acceptance (0 = idle).
  int               pos = 0;
  logic [AW-1:0]    m_addr = '0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_clr = 1'b0;

  always #5 clk = ~clk;

  latch_wr_sequencer #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef LATCH_WR_SEQ_CLEAR_EN
    .clr_req  (clr_req),
`endif
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .lat_en   (lat_en),
    .lat_d    (lat_d),
    .busy     (busy),
    .err      (err)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Sequence rules: SETUP_CYC setup cycles, one pulse cycle, HOLD_CYC hold
  // cycles, then an idle cycle in which the next write can be taken.
  task automatic modelStep();
    exp_t             e;
    logic [DEPTH-1:0] en;
    if (!rst) begin
      pos    = 0;
      m_data = '0;
      m_addr = '0;
      m_clr  = 1'b0;
    end else if (pos == 0) begin
      if (CLR_EN && clr_req) begin
        pos = 1; m_clr = 1'b1; m_data = '0; m_addr = '0;
      end else if (wr_valid) begin
        pos = 1; m_clr = 1'b0; m_data = wr_data; m_addr = wr_addr;
      end
    end else if (pos == SEQ_LEN - 1) begin
      pos = 0;
    end else begin
      pos++;
    end
    en = '0;
    if (pos == SETUP_CYC + 1) begin
      if (m_clr) en = '1;
      else if (int'(m_addr) < DEPTH) en[m_addr] = 1'b1;
    end
    e.ready = (pos == 0);
    e.busy  = (pos != 0);
    e.err   = (pos == 1) && !m_clr && (int'(m_addr) >= DEPTH);
    e.en    = en;
    e.d     = m_data;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic c,
                               input logic [AW-1:0] a, input logic [WIDTH-1:0] dt);
    rst      = r;
    wr_valid = v;
    clr_req  = c;
    wr_addr  = a;
    wr_data  = dt;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("wr_ready", {31'd0, wr_ready}, {31'd0, e.ready});
    cmp("busy",     {31'd0, busy},     {31'd0, e.busy});
    cmp("err",      {31'd0, err},      {31'd0, e.err});
    cmp("lat_en",   32'(lat_en),       32'(e.en));
    cmp("lat_d",    32'(lat_d),        32'(e.d));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset for two cycles, then a quiet cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    idle(1);

    // Single write.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd3, 8'hA5);
    idle(SEQ_LEN);

    // Back-to-back with valid held high; second request is waiting early.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd1, 8'h11);
    for (int i = 0; i < SEQ_LEN; i++) applyStimulus(1'b1, 1'b1, 1'b0, 3'd4, 8'h66);
    idle(SEQ_LEN);

    // Out-of-range address.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd6, 8'h77);
    idle(SEQ_LEN);

    // Reset during SETUP.
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd2, 8'h5A);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    idle(SEQ_LEN);

    // Clear together with a write request.
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd2, 8'hFF);
    idle(SEQ_LEN);

    // Randomized traffic with occasional resets and clears.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 7) == 0),
                    AW'($urandom_range(0, (1 << AW) - 1)),
                    WIDTH'($urandom));
    end
    idle(SEQ_LEN);

    @(negedge clk);
    cmp("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
